// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the two-master bus arbiter
//
// Purpose : arbiter state encoding, one-hot grant encodings and the
//           watchdog counter width used by bus_arbiter2 and bus_wdog.
package bus_arb_pkg;

   localparam int WDOG_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   // One-hot grant matching a given arbiter state.
   function automatic logic [1:0] grant_of(arb_state_e s);
      case (s)
         GNT0:    grant_of = GRANT_M0;
         GNT1:    grant_of = GRANT_M1;
         default: grant_of = GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/bus_wdog.sv
// rtl/bus_wdog.sv - saturating per-transfer watchdog counter
//
// Purpose : counts enabled cycles from zero and holds at LIMIT; o_expire is
//           high while the count equals LIMIT.
// Ports   : clk, reset_n (sync, active-low)
//           i_clear  - return count to zero (wins over i_enable)
//           i_enable - advance count by one this cycle (until saturated)
//           o_expire - count has reached LIMIT
module bus_wdog
   import bus_arb_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [WDOG_WIDTH-1:0] LIMIT_C = WDOG_WIDTH'(LIMIT);

   logic [WDOG_WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT_C)) begin
         // Stop at LIMIT so a stuck slave never wraps the count back to zero.
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = (r_count == LIMIT_C);

endmodule

// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - round-robin two-master arbiter for the valid/ready memory bus
//
// Purpose : shares one downstream valid/ready port between master 0 (CPU)
//           and master 1 (DMA/loader). Grant is registered in IDLE and held
//           until completion, watchdog timeout or master withdrawal.
// Ports   : clk, reset_n (sync, active-low)
//           m0_* / m1_*  - upstream masters: valid, addr, wdata, wstrb in;
//                          rdata, ready out
//           s_*          - downstream: valid, addr, wdata, wstrb out;
//                          rdata, ready in
//           grant        - one-hot owner (00 idle, 01 m0, 10 m1)
//           timeout_err  - single-cycle pulse on watchdog termination
module bus_arbiter2
   import bus_arb_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   arb_state_e  r_state;
   logic        r_last_grant;   // 1: master 1 was the last to complete
   logic [1:0]  r_grant;

   logic        w_in_gnt;
   logic        w_sel_valid;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [3:0]  w_sel_wstrb;
   logic        w_expire;
   logic        w_complete;
   logic        w_timeout;
   logic        w_withdraw;
   logic        w_resp_ready;
   logic [31:0] w_resp_rdata;

   // Owner's request selected by the state register.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_wstrb = '0;
      case (r_state)
         GNT0: begin
            w_sel_valid = m0_valid;
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
            w_sel_wstrb = m0_wstrb;
         end
         GNT1: begin
            w_sel_valid = m1_valid;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_wstrb = m1_wstrb;
         end
         default: ;
      endcase
   end

   assign w_in_gnt   = (r_state != IDLE);
   assign w_complete = w_in_gnt & w_sel_valid & s_ready;
   // A late s_ready in the expiry cycle still completes normally.
   assign w_timeout  = w_in_gnt & w_sel_valid & ~s_ready & w_expire;
   assign w_withdraw = w_in_gnt & ~w_sel_valid;

   bus_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clear  (~w_in_gnt),
      .i_enable (w_in_gnt & ~s_ready),
      .o_expire (w_expire)
   );

   // Downstream request; suppressed in the cycle the watchdog terminates it.
   assign s_valid = w_sel_valid & ~w_timeout;
   assign s_addr  = w_sel_addr;
   assign s_wdata = w_sel_wdata;
   assign s_wstrb = w_sel_wstrb;

   // Response to the owner; gated by its valid so a withdrawn master sees no ready.
   assign w_resp_ready = w_complete | w_timeout;
   assign w_resp_rdata = w_timeout ? TIMEOUT_RDATA : s_rdata;

   assign m0_ready = (r_state == GNT0) & w_resp_ready;
   assign m1_ready = (r_state == GNT1) & w_resp_ready;
   assign m0_rdata = (r_state == GNT0) ? w_resp_rdata : '0;
   assign m1_rdata = (r_state == GNT1) ? w_resp_rdata : '0;

   assign grant       = r_grant;
   assign timeout_err = w_timeout;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= GRANT_NONE;
      end else begin
         case (r_state)
            IDLE: begin
               // m0 wins contention unless it was the last master served.
               if (m0_valid && (!m1_valid || r_last_grant)) begin
                  r_state <= GNT0;
                  r_grant <= grant_of(GNT0);
               end else if (m1_valid) begin
                  r_state <= GNT1;
                  r_grant <= grant_of(GNT1);
               end
            end
            GNT0, GNT1: begin
               if (w_withdraw) begin
                  // Abandoned request does not count as a turn.
                  r_state <= IDLE;
                  r_grant <= GRANT_NONE;
               end else if (w_complete || w_timeout) begin
                  r_state      <= IDLE;
                  r_grant      <= GRANT_NONE;
                  r_last_grant <= (r_state == GNT1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= GRANT_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb/tb_bus_arbiter2.sv - directed self-checking bench for bus_arbiter2
module tb_bus_arbiter2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_valid, m1_valid, s_ready;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic        m0_ready, m1_ready, s_valid, timeout_err;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   bus_arbiter2 #(
      .TIMEOUT_CYCLES (8),
      .TIMEOUT_RDATA  (32'hDEAD_BEEF)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0_valid    (m0_valid),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_wstrb    (m0_wstrb),
      .m0_rdata    (m0_rdata),
      .m0_ready    (m0_ready),
      .m1_valid    (m1_valid),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_wstrb    (m1_wstrb),
      .m1_rdata    (m1_rdata),
      .m1_ready    (m1_ready),
      .s_valid     (s_valid),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_rdata     (s_rdata),
      .s_ready     (s_ready),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Slave completes the owner's transfer next cycle, then the owner drops valid.
   task automatic complete(input bit who, input logic [31:0] rd);
      tick();
      s_ready = 1'b1;
      s_rdata = rd;
      settle();
      chk("done_m0_ready", {31'd0, m0_ready}, {31'd0, !who});
      chk("done_m1_ready", {31'd0, m1_ready}, {31'd0, who});
      chk("done_rdata", who ? m1_rdata : m0_rdata, rd);
      chk("done_other_rdata", who ? m0_rdata : m1_rdata, 32'h0);
      chk("done_tmo", {31'd0, timeout_err}, 32'd0);
      tick();
      if (who) m1_valid = 1'b0; else m0_valid = 1'b0;
      s_ready = 1'b0;
      s_rdata = '0;
      settle();
      chk("done_idle_grant", {30'd0, grant}, 32'd0);
      chk("done_idle_svalid", {31'd0, s_valid}, 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_ready  = 1'b0; s_rdata = '0;
      tick();
      tick();
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_svalid", {31'd0, s_valid}, 32'd0);
      chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      chk("rst_saddr", s_addr, 32'h0);
      reset_n = 1'b1;

      // Contention right after reset: m0 first, m1 two cycles after m0 completes.
      m0_valid = 1'b1; m0_addr = 32'h0000_1000;
      m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wdata = 32'h0BAD_F00D; m1_wstrb = 4'hF;
      tick();
      settle();
      chk("cont_grant_m0", {30'd0, grant}, 32'd1);
      chk("cont_saddr_m0", s_addr, 32'h0000_1000);
      complete(1'b0, 32'h0000_00A0);
      tick();
      settle();
      chk("cont_grant_m1", {30'd0, grant}, 32'd2);
      chk("cont_saddr_m1", s_addr, 32'h0000_2000);
      chk("cont_wdata_m1", s_wdata, 32'h0BAD_F00D);
      chk("cont_wstrb_m1", {28'd0, s_wstrb}, 32'hF);
      complete(1'b1, 32'h0);

      // Single master read, slave ready at t+2.
      m0_valid = 1'b1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0; m0_wdata = '0;
      settle();
      chk("single_idle_svalid", {31'd0, s_valid}, 32'd0);
      tick();
      settle();
      chk("single_grant", {30'd0, grant}, 32'd1);
      chk("single_svalid", {31'd0, s_valid}, 32'd1);
      chk("single_saddr", s_addr, 32'h4000_0010);
      chk("single_swstrb", {28'd0, s_wstrb}, 32'd0);
      chk("single_m0_ready_early", {31'd0, m0_ready}, 32'd0);
      complete(1'b0, 32'h1234_5678);

      // Second pair after m0 was last: m1 first, then m0.
      m0_valid = 1'b1; m0_addr = 32'h0000_3000;
      m1_valid = 1'b1; m1_addr = 32'h0000_4000; m1_wstrb = 4'h0;
      tick();
      settle();
      chk("pair2_grant_m1", {30'd0, grant}, 32'd2);
      complete(1'b1, 32'h0000_00B1);
      tick();
      settle();
      chk("pair2_grant_m0", {30'd0, grant}, 32'd1);
      complete(1'b0, 32'h0000_00B0);

      // Held-off write from m1 while m0 owns the bus.
      m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111; m0_wstrb = 4'h0;
      tick();
      settle();
      chk("hold_grant_m0", {30'd0, grant}, 32'd1);
      m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'hCAFE_BABE; m1_wstrb = 4'b0011;
      settle();
      chk("hold_wdata_m0", s_wdata, 32'h1111_1111);
      chk("hold_wstrb_m0", {28'd0, s_wstrb}, 32'd0);
      chk("hold_saddr_m0", s_addr, 32'h0000_0100);
      tick();
      settle();
      chk("hold_still_m0", {30'd0, grant}, 32'd1);
      chk("hold_m1_ready", {31'd0, m1_ready}, 32'd0);
      complete(1'b0, 32'hAAAA_5555);
      chk("hold_idle_wdata", s_wdata, 32'h0);
      chk("hold_idle_wstrb", {28'd0, s_wstrb}, 32'd0);
      tick();
      settle();
      chk("hold_grant_m1", {30'd0, grant}, 32'd2);
      chk("hold_wdata_m1", s_wdata, 32'hCAFE_BABE);
      chk("hold_wstrb_m1", {28'd0, s_wstrb}, 32'h3);
      complete(1'b1, 32'h0);

      // Withdrawal: no ready, and the turn is not consumed (m0 still wins next pair).
      m0_valid = 1'b1; m0_addr = 32'h0000_0500;
      tick();
      settle();
      chk("wd_grant", {30'd0, grant}, 32'd1);
      m0_valid = 1'b0;
      settle();
      chk("wd_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("wd_svalid", {31'd0, s_valid}, 32'd0);
      tick();
      settle();
      chk("wd_idle", {30'd0, grant}, 32'd0);
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      settle();
      chk("wd_pair_m0", {30'd0, grant}, 32'd1);
      complete(1'b0, 32'h0000_00C0);
      tick();
      settle();
      chk("wd_pair_m1", {30'd0, grant}, 32'd2);
      complete(1'b1, 32'h0000_00C1);

      // Timeout: slave never ready, termination on the 9th grant cycle.
      m0_valid = 1'b1; m0_addr = 32'h0000_0600;
      tick();
      for (int k = 1; k <= 8; k++) begin
         settle();
         chk("tmo_wait_ready", {31'd0, m0_ready}, 32'd0);
         chk("tmo_wait_err", {31'd0, timeout_err}, 32'd0);
         tick();
      end
      settle();
      chk("tmo_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("tmo_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("tmo_err", {31'd0, timeout_err}, 32'd1);
      chk("tmo_svalid", {31'd0, s_valid}, 32'd0);
      tick();
      m0_valid = 1'b0;
      settle();
      chk("tmo_err_once", {31'd0, timeout_err}, 32'd0);
      chk("tmo_idle", {30'd0, grant}, 32'd0);

      // Race: s_ready arrives in the expiry cycle, normal completion wins.
      m0_valid = 1'b1; m0_addr = 32'h0000_0700; s_rdata = 32'h5A5A_0001;
      tick();
      for (int k = 1; k <= 8; k++) begin
         settle();
         tick();
      end
      s_ready = 1'b1;
      settle();
      chk("race_m0_ready", {31'd0, m0_ready}, 32'd1);
      chk("race_m0_rdata", m0_rdata, 32'h5A5A_0001);
      chk("race_err", {31'd0, timeout_err}, 32'd0);
      chk("race_svalid", {31'd0, s_valid}, 32'd1);
      tick();
      m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
      settle();
      chk("race_idle", {30'd0, grant}, 32'd0);

      // Reset during GNT1 (m0 was last, so only the reset hands m0 the next pair).
      m1_valid = 1'b1; m1_addr = 32'h0000_0800;
      tick();
      settle();
      chk("rmid_grant_m1", {30'd0, grant}, 32'd2);
      reset_n = 1'b0;
      tick();
      s_ready = 1'b1;
      settle();
      chk("rmid_grant", {30'd0, grant}, 32'd0);
      chk("rmid_svalid", {31'd0, s_valid}, 32'd0);
      chk("rmid_saddr", s_addr, 32'h0);
      chk("rmid_m1_ready", {31'd0, m1_ready}, 32'd0);
      reset_n = 1'b1; s_ready = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h0000_0900;
      tick();
      settle();
      chk("rmid_pair_m0", {30'd0, grant}, 32'd1);
      complete(1'b0, 32'h0000_00D0);
      tick();
      settle();
      chk("rmid_pair_m1", {30'd0, grant}, 32'd2);
      complete(1'b1, 32'h0000_00D1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
